// File: rtl/mem_result_checker_pkg.sv
// Shared encodings for the post-halt memory result checker: check modes, FSM states, word sizing.
// No logic; latency and backpressure are properties of the modules that import this package.
package chk_pkg;

  typedef enum logic [1:0] {
    MODE_FIBO = 2'd0,
    MODE_ASC  = 2'd1,
    MODE_DESC = 2'd2,
    MODE_RSVD = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_FIN
  } state_e;

  localparam int IDX_W = 16;

  function automatic int bytes_per_word(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/mem_result_checker_if.sv
// Data-memory read handshake shared by the checker (master) and memory (slave).
// One-cycle rd_req; the slave answers with rd_valid/rd_data whenever it is ready.
interface mem_result_checker_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 64
) ();
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;

  modport master (output rd_req, output rd_addr, input rd_valid, input rd_data);
  modport slave  (input rd_req, input rd_addr, output rd_valid, output rd_data);
endinterface

// File: rtl/mem_result_checker_rule.sv
// Combinational per-word property check: ok when rd_data satisfies the selected mode.
// Zero latency, no backpressure; the caller decides when the result is used.
module chk_rule
  import chk_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int SIGNED = 1
) (
  input  mode_e             mode,
  input  logic              first,
  input  logic              second,
  input  logic [DATA_W-1:0] data,
  input  logic [DATA_W-1:0] prev1,
  input  logic [DATA_W-1:0] prev2,
  output logic              ok
);

  logic              lt;
  logic              gt;
  logic [DATA_W-1:0] sum;

  assign sum = prev1 + prev2;

  always_comb begin
    if (SIGNED != 0) begin
      lt = $signed(data) < $signed(prev1);
      gt = $signed(data) > $signed(prev1);
    end else begin
      lt = data < prev1;
      gt = data > prev1;
    end
  end

  always_comb begin
    ok = 1'b0;
    case (mode)
      MODE_FIBO: ok = (first || second) ? (data == DATA_W'(1)) : (data == sum);
      MODE_ASC:  ok = first || !lt;
      MODE_DESC: ok = first || !gt;
      default:   ok = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_result_checker.sv
// On a halt rising edge, reads COUNT words from BASE_IDX and checks the selected property.
// Two cycles per word with 1-cycle memory; waits up to TIMEOUT cycles per read for rd_valid.
module mem_result_checker
  import chk_pkg::*;
#(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 64,
  parameter int BASE_IDX = 1,
  parameter int COUNT    = 20,
  parameter int SIGNED   = 1,
  parameter int TIMEOUT  = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                halt,
  input  logic [1:0]          mode,
  mem_result_checker_if.master mem,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic                timeout,
  output logic [IDX_W-1:0]    err_idx
);

  localparam int               BPW     = bytes_per_word(DATA_W);
  localparam logic [IDX_W-1:0] BASE    = IDX_W'(BASE_IDX);
  localparam logic [IDX_W-1:0] LAST    = IDX_W'(COUNT - 1);
  localparam logic [IDX_W-1:0] TO_LAST = IDX_W'(TIMEOUT - 1);

  state_e            state_q;
  mode_e             mode_q;
  logic              halt_q;
  logic [IDX_W-1:0]  idx_q, cnt_q, wait_q;
  logic [DATA_W-1:0] prev1_q, prev2_q;
  logic              rd_req_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic              busy_q, done_q, pass_q, timeout_q;
  logic [IDX_W-1:0]  err_idx_q;
  logic              rule_ok;

  function automatic logic [ADDR_W-1:0] addr_of(input logic [IDX_W-1:0] i);
    return ADDR_W'(i) * ADDR_W'(BPW);
  endfunction

  chk_rule #(.DATA_W(DATA_W), .SIGNED(SIGNED)) u_rule (
    .mode   (mode_q),
    .first  (cnt_q == '0),
    .second (cnt_q == IDX_W'(1)),
    .data   (mem.rd_data),
    .prev1  (prev1_q),
    .prev2  (prev2_q),
    .ok     (rule_ok)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      mode_q    <= MODE_FIBO;
      halt_q    <= 1'b0;
      idx_q     <= '0;
      cnt_q     <= '0;
      wait_q    <= '0;
      prev1_q   <= '0;
      prev2_q   <= '0;
      rd_req_q  <= 1'b0;
      rd_addr_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      timeout_q <= 1'b0;
      err_idx_q <= '0;
    end else begin
      halt_q   <= halt;
      rd_req_q <= 1'b0;
      case (state_q)
        S_IDLE: if (halt && !halt_q) begin
          mode_q    <= mode_e'(mode);
          idx_q     <= BASE;
          cnt_q     <= '0;
          busy_q    <= 1'b1;
          done_q    <= 1'b0;
          pass_q    <= 1'b0;
          timeout_q <= 1'b0;
          err_idx_q <= '0;
          if (mode_e'(mode) == MODE_RSVD) begin
            err_idx_q <= BASE;
            state_q   <= S_FIN;
          end else if (COUNT == 0) begin
            pass_q  <= 1'b1;
            state_q <= S_FIN;
          end else begin
            rd_req_q  <= 1'b1;
            rd_addr_q <= addr_of(BASE);
            state_q   <= S_REQ;
          end
        end
        S_REQ: begin
          wait_q  <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (mem.rd_valid) begin
            if (!rule_ok) begin
              err_idx_q <= idx_q;
              state_q   <= S_FIN;
            end else begin
              prev2_q <= prev1_q;
              prev1_q <= mem.rd_data;
              idx_q   <= idx_q + IDX_W'(1);
              cnt_q   <= cnt_q + IDX_W'(1);
              if (cnt_q == LAST) begin
                pass_q  <= 1'b1;
                state_q <= S_FIN;
              end else begin
                rd_req_q  <= 1'b1;
                rd_addr_q <= addr_of(idx_q + IDX_W'(1));
                state_q   <= S_REQ;
              end
            end
          end else if (wait_q == TO_LAST) begin
            timeout_q <= 1'b1;
            err_idx_q <= idx_q;
            state_q   <= S_FIN;
          end else begin
            wait_q <= wait_q + IDX_W'(1);
          end
        end
        S_FIN: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem.rd_req  = rd_req_q;
  assign mem.rd_addr = rd_addr_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign timeout     = timeout_q;
  assign err_idx     = err_idx_q;

endmodule

// File: tb/tb_mem_result_checker.sv
// Bench for mem_result_checker: three instances (COUNT=20, COUNT=10, COUNT=0) with behavioural memories.
// Expected results are queued at each start and compared when done rises.
module tb_mem_result_checker;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [1:0]            mode = 2'd0;
  logic [2:0]            halt_v = 3'b000;
  logic [2:0]            busy_v, done_v, pass_v, to_v;
  logic [2:0][15:0]      err_v;

  logic [63:0] mem_a [0:31];
  logic [63:0] mem_b [0:31];
  int          stall_a = -1, stall_b = -1;
  int          reads_c [3];
  logic        pend_a = 1'b0, pend_b = 1'b0;
  int          pidx_a = 0, pidx_b = 0;

  int passed = 0;
  int total  = 0;

  mem_result_checker_if #(.DATA_W(64), .ADDR_W(64)) ifa ();
  mem_result_checker_if #(.DATA_W(64), .ADDR_W(64)) ifb ();
  mem_result_checker_if #(.DATA_W(64), .ADDR_W(64)) ifc ();

  mem_result_checker #(.COUNT(20)) dut_a (
    .clk(clk), .rst(rst), .halt(halt_v[0]), .mode(mode), .mem(ifa),
    .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]), .timeout(to_v[0]), .err_idx(err_v[0])
  );
  mem_result_checker #(.COUNT(10)) dut_b (
    .clk(clk), .rst(rst), .halt(halt_v[1]), .mode(mode), .mem(ifb),
    .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]), .timeout(to_v[1]), .err_idx(err_v[1])
  );
  mem_result_checker #(.COUNT(0)) dut_c (
    .clk(clk), .rst(rst), .halt(halt_v[2]), .mode(mode), .mem(ifc),
    .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]), .timeout(to_v[2]), .err_idx(err_v[2])
  );

  initial forever #5 clk = ~clk;

  // Memories answer one cycle after the request; a stalled index never answers.
  always @(negedge clk) begin
    if (rst) begin
      pend_a = 1'b0; ifa.rd_valid = 1'b0; ifa.rd_data = '0;
      pend_b = 1'b0; ifb.rd_valid = 1'b0; ifb.rd_data = '0;
    end else begin
      ifa.rd_valid = 1'b0;
      if (pend_a && pidx_a != stall_a) begin ifa.rd_valid = 1'b1; ifa.rd_data = mem_a[pidx_a]; end
      pend_a = ifa.rd_req;
      if (ifa.rd_req) begin pidx_a = int'(ifa.rd_addr >> 3); reads_c[0]++; end
      ifb.rd_valid = 1'b0;
      if (pend_b && pidx_b != stall_b) begin ifb.rd_valid = 1'b1; ifb.rd_data = mem_b[pidx_b]; end
      pend_b = ifb.rd_req;
      if (ifb.rd_req) begin pidx_b = int'(ifb.rd_addr >> 3); reads_c[1]++; end
    end
  end

  initial begin
    ifc.rd_valid = 1'b0;
    ifc.rd_data  = '0;
  end

  typedef struct {
    logic  pass;
    logic  to;
    int    err;
    int    lat;
    int    reads;
    string name;
  } exp_t;

  typedef struct {
    int          dsel;
    logic [1:0]  mode;
    int          ds;
    int          stall;
    exp_t        e;
  } vec_t;

  exp_t sb[$];

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic load(input int ds);
    longint f1, f2, t;
    longint asc [10];
    asc = '{-5, -3, 0, 0, 4, 9, 9, 12, 30, 31};
    for (int i = 0; i < 32; i++) begin mem_a[i] = '0; mem_b[i] = '0; end
    f1 = 1; f2 = 1;
    for (int i = 1; i <= 20; i++) begin
      mem_a[i] = 64'(f1);
      t = f1 + f2; f1 = f2; f2 = t;
    end
    if (ds == 1) mem_a[7] = 64'd20;
    for (int i = 0; i < 10; i++) mem_b[i+1] = 64'(asc[i]);
  endtask

  // Called after edge E0; counts edges from there until done rises.
  task automatic wait_done(input int d, input int lat0);
    exp_t e;
    int   lat;
    bit   got;
    lat = lat0; got = 1'b0;
    while (!got && lat < 300) begin
      @(posedge clk); #1;
      lat++;
      if (done_v[d]) got = 1'b1;
    end
    if (sb.size() == 0) begin
      check("scoreboard_empty", 1, 0);
      return;
    end
    e = sb.pop_front();
    if (!got) begin
      check({e.name, "_done_seen"}, 0, 1);
      return;
    end
    check({e.name, "_lat"},     lat, e.lat);
    check({e.name, "_pass"},    longint'(pass_v[d]), longint'(e.pass));
    check({e.name, "_timeout"}, longint'(to_v[d]), longint'(e.to));
    check({e.name, "_err_idx"}, longint'(err_v[d]), e.err);
    check({e.name, "_reads"},   reads_c[d], e.reads);
    check({e.name, "_busy"},    longint'(busy_v[d]), 0);
  endtask

  task automatic run_vec(input vec_t v);
    halt_v[v.dsel] = 1'b0;
    mode    = v.mode;
    stall_a = v.stall;
    stall_b = v.stall;
    load(v.ds);
    repeat (2) @(posedge clk);
    #1;
    reads_c[v.dsel] = 0;
    sb.push_back(v.e);
    halt_v[v.dsel] = 1'b1;
    @(posedge clk); #1;
    wait_done(v.dsel, 0);
  endtask

  vec_t vecs [7];
  exp_t rexp;

  initial begin
    vecs[0] = '{0, 2'd0, 0, -1, '{1'b1, 1'b0, 0, 41, 20, "fibo"}};
    vecs[1] = '{0, 2'd0, 1, -1, '{1'b0, 1'b0, 7, 15, 7,  "fibo_bad7"}};
    vecs[2] = '{1, 2'd1, 2, -1, '{1'b1, 1'b0, 0, 21, 10, "asc"}};
    vecs[3] = '{1, 2'd2, 2, -1, '{1'b0, 1'b0, 2, 5,  2,  "desc"}};
    vecs[4] = '{0, 2'd0, 0, 3,  '{1'b0, 1'b1, 3, 21, 3,  "timeout"}};
    vecs[5] = '{0, 2'd3, 0, -1, '{1'b0, 1'b0, 1, 1,  0,  "rsvd"}};
    vecs[6] = '{2, 2'd0, 0, -1, '{1'b1, 1'b0, 0, 1,  0,  "count0"}};
    for (int i = 0; i < 3; i++) reads_c[i] = 0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",    longint'(busy_v[0]), 0);
    check("rst_done",    longint'(done_v[0]), 0);
    check("rst_pass",    longint'(pass_v[0]), 0);
    check("rst_err_idx", longint'(err_v[0]), 0);
    check("rst_rd_addr", longint'(ifa.rd_addr), 0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Reset mid-check, with halt held high through and after reset.
    halt_v[0] = 1'b0;
    mode = 2'd0; stall_a = -1;
    load(0);
    repeat (2) @(posedge clk);
    #1;
    reads_c[0] = 0;
    halt_v[0] = 1'b1;
    for (int n = 0; n < 100 && reads_c[0] < 5; n++) begin @(posedge clk); #1; end
    check("word5_reached", reads_c[0], 5);
    rst = 1'b1;
    #2;
    check("midrst_busy",    longint'(busy_v[0]), 0);
    check("midrst_done",    longint'(done_v[0]), 0);
    check("midrst_pass",    longint'(pass_v[0]), 0);
    check("midrst_timeout", longint'(to_v[0]), 0);
    check("midrst_rd_req",  longint'(ifa.rd_req), 0);
    check("midrst_rd_addr", longint'(ifa.rd_addr), 0);
    @(negedge clk);
    #2;
    reads_c[0] = 0;
    rexp = '{1'b1, 1'b0, 0, 41, 20, "restart"};
    sb.push_back(rexp);
    rst = 1'b0;
    @(posedge clk); #1;
    check("restart_rd_req",  longint'(ifa.rd_req), 1);
    check("restart_rd_addr", longint'(ifa.rd_addr), 8);
    check("restart_busy",    longint'(busy_v[0]), 1);
    // A fresh halt edge while busy must not disturb the running check.
    halt_v[0] = 1'b0;
    @(posedge clk); #1;
    halt_v[0] = 1'b1;
    @(posedge clk); #1;
    wait_done(0, 2);
    repeat (4) @(posedge clk);
    #1;
    check("done_held",  longint'(done_v[0]), 1);
    check("pass_held",  longint'(pass_v[0]), 1);
    check("no_restart", longint'(busy_v[0]), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
